// File: rtl/sseg_display_pkg.sv
// ============================================================================
// Module  : sseg_display_pkg
// Purpose : Shared converter state type and 7-segment glyph codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  // Active-low segment codes, bit7 = dp (off), bits6:0 = g..a
  localparam logic [7:0] c_GLYPH_0 = 8'hC0;
  localparam logic [7:0] c_GLYPH_1 = 8'hF9;
  localparam logic [7:0] c_GLYPH_2 = 8'hA4;
  localparam logic [7:0] c_GLYPH_3 = 8'hB0;
  localparam logic [7:0] c_GLYPH_4 = 8'h99;
  localparam logic [7:0] c_GLYPH_5 = 8'h92;
  localparam logic [7:0] c_GLYPH_6 = 8'h82;
  localparam logic [7:0] c_GLYPH_7 = 8'hF8;
  localparam logic [7:0] c_GLYPH_8 = 8'h80;
  localparam logic [7:0] c_GLYPH_9 = 8'h90;
  localparam logic [7:0] c_GLYPH_A = 8'h88;
  localparam logic [7:0] c_GLYPH_B = 8'h83;
  localparam logic [7:0] c_GLYPH_C = 8'hC6;
  localparam logic [7:0] c_GLYPH_D = 8'hA1;
  localparam logic [7:0] c_GLYPH_E = 8'h86;
  localparam logic [7:0] c_GLYPH_F = 8'h8E;
  localparam logic [7:0] c_SEG_BLANK = 8'hFF;
  localparam logic [7:0] c_SEG_DASH  = 8'hBF;

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = c_GLYPH_0;
      4'h1:    code = c_GLYPH_1;
      4'h2:    code = c_GLYPH_2;
      4'h3:    code = c_GLYPH_3;
      4'h4:    code = c_GLYPH_4;
      4'h5:    code = c_GLYPH_5;
      4'h6:    code = c_GLYPH_6;
      4'h7:    code = c_GLYPH_7;
      4'h8:    code = c_GLYPH_8;
      4'h9:    code = c_GLYPH_9;
      4'hA:    code = c_GLYPH_A;
      4'hB:    code = c_GLYPH_B;
      4'hC:    code = c_GLYPH_C;
      4'hD:    code = c_GLYPH_D;
      4'hE:    code = c_GLYPH_E;
      default: code = c_GLYPH_F;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module  : bin_to_bcd_seq
// Purpose : Sequential double-dabble converter with hex bypass and overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
  import sseg_display_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DIGITS     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_value,
  input  logic                    i_hex,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ADDR_WIDTH-1:0]   o_src_value,
  output logic                    o_src_hex,
  output logic [4*DIGITS-1:0]     o_nibbles,
  output logic                    o_overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int PAD_W = (ADDR_WIDTH > BCD_W) ? ADDR_WIDTH : BCD_W;
  localparam int CNT_W = $clog2(ADDR_WIDTH + 1);

  conv_state_t             r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic                    r_hex;
  logic [ADDR_WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]        r_bcd;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_cnt;

  logic [BCD_W-1:0]        w_adj;
  logic [PAD_W-1:0]        w_pad;
  logic                    w_hex_ovf;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_pad     = PAD_W'(r_src);
  assign w_hex_ovf = |(w_pad >> BCD_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_src   <= '0;
      r_hex   <= 1'b0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_src   <= i_value;
          r_hex   <= i_hex;
          r_shift <= i_value;
          r_bcd   <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
          if (i_hex) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A set MSB after adjustment means the value needs one more digit.
          r_bcd   <= {w_adj[BCD_W-2:0], r_shift[ADDR_WIDTH-1]};
          r_shift <= r_shift << 1;
          r_ovf   <= r_ovf | w_adj[BCD_W-1];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_src_value = r_src;
  assign o_src_hex   = r_hex;
  assign o_nibbles   = r_hex ? w_pad[BCD_W-1:0] : r_bcd;
  assign o_overflow  = r_hex ? w_hex_ovf : r_ovf;

endmodule

`default_nettype wire

// File: rtl/multiplexed_sseg_display.sv
// ============================================================================
// Module  : multiplexed_sseg_display
// Purpose : Binary-to-digit conversion feeding a time-multiplexed 7-seg scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplexed_sseg_display
  import sseg_display_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_line,
  input  logic                  hex_mode,
  input  logic                  blank_leading,
  output logic [7:0]            sseg_indicator,
  output logic [DIGITS-1:0]     digits,
  output logic                  busy
);

  localparam int   BCD_W = 4 * DIGITS;
  localparam int   PRE_W = $clog2(REFRESH_DIV);
  localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic c_INV = (ACTIVE_LOW == 0);

  logic                    r_pending;
  logic [BCD_W-1:0]        r_disp;
  logic                    r_disp_ovf;
  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [7:0]              r_sseg;
  logic [DIGITS-1:0]       r_digits;

  logic                    w_busy;
  logic                    w_done;
  logic                    w_start;
  logic [ADDR_WIDTH-1:0]   w_src_value;
  logic                    w_src_hex;
  logic [BCD_W-1:0]        w_nibbles;
  logic                    w_overflow;
  logic                    w_slot_end;
  logic [PRE_W-1:0]        w_presc_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [DIGITS-1:0]       w_lead_zero;
  logic                    w_zero_above;
  logic [7:0]              w_glyph;
  logic [DIGITS-1:0]       w_sel;

  assign w_start = !w_busy && (r_pending || (address_line != w_src_value) ||
                               (hex_mode != w_src_hex));

  bin_to_bcd_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIGITS     (DIGITS)
  ) u_conv (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_value     (address_line),
    .i_hex       (hex_mode),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_src_value (w_src_value),
    .o_src_hex   (w_src_hex),
    .o_nibbles   (w_nibbles),
    .o_overflow  (w_overflow)
  );

  assign w_slot_end  = (r_presc == PRE_W'(REFRESH_DIV - 1));
  assign w_presc_nxt = w_slot_end ? '0 : r_presc + PRE_W'(1);
  assign w_idx_nxt   = !w_slot_end ? r_idx :
                       (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);

  // Glyph and select are built for the slot the counters are about to enter.
  always_comb begin
    w_lead_zero  = '0;
    w_zero_above = 1'b1;
    for (int p = DIGITS - 1; p >= 0; p--) begin
      w_lead_zero[p] = w_zero_above && (r_disp[4*p +: 4] == 4'd0) && (p != 0);
      w_zero_above   = w_lead_zero[p];
    end
    w_glyph = c_SEG_BLANK;
    w_sel   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_sel[DIGITS-1-k] = 1'b0;
        if (r_disp_ovf) begin
          w_glyph = c_SEG_DASH;
        end else if (blank_leading && w_lead_zero[DIGITS-1-k]) begin
          w_glyph = c_SEG_BLANK;
        end else begin
          w_glyph = glyph(r_disp[4*(DIGITS-1-k) +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending  <= 1'b1;
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
      r_presc    <= '0;
      r_idx      <= '0;
      r_sseg     <= c_SEG_BLANK ^ {8{c_INV}};
      r_digits   <= {DIGITS{~c_INV}};
    end else begin
      if (w_start) begin
        r_pending <= 1'b0;
      end
      if (w_done) begin
        r_disp     <= w_nibbles;
        r_disp_ovf <= w_overflow;
      end
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
      r_sseg  <= w_glyph ^ {8{c_INV}};
      // Selects stay dark for the first clock of each slot to avoid ghosting.
      if (w_presc_nxt == '0) begin
        r_digits <= {DIGITS{~c_INV}};
      end else begin
        r_digits <= w_sel ^ {DIGITS{c_INV}};
      end
    end
  end

  assign sseg_indicator = r_sseg;
  assign digits         = r_digits;
  assign busy           = w_busy;

endmodule

`default_nettype wire

// File: doc/multiplexed_sseg_display.md
MULTIPLEXED_SSEG_DISPLAY -- requirements
Module: multiplexed_sseg_display

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, width of displayed binary value.
REQ-002 SHALL have parameter DIGITS, default 4, number of multiplexed 7-segment digits (1..8).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = segments and digit selects active-low, 0 = both inverted.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port address_line  input  ADDR_WIDTH  binary value to display.
REQ-008 SHALL have port hex_mode  input  1  1 = hexadecimal, 0 = decimal.
REQ-009 SHALL have port blank_leading  input  1  1 = blank leading zeros.
REQ-010 SHALL have port sseg_indicator  output  8  bit7 = dp, bits6:0 = g..a.
REQ-011 SHALL have port digits  output  DIGITS  digit select, one active at a time.
REQ-012 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-013 Converter FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-014 In IDLE, start SHALL occur when address_line/hex_mode differ from last converted pair, or first cycle after reset release; IDLE->LOAD.
REQ-015 LOAD: capture address_line and hex_mode, clear BCD accumulators, busy=1; next SHIFT (decimal) or DONE (hex).
REQ-016 SHIFT: one double-dabble iteration per clock (add 3 to every nibble >=5, then shift left one bit), exactly ADDR_WIDTH cycles, then DONE.
REQ-017 DONE: atomically write all DIGITS nibbles plus overflow flag to display register, busy=0, next IDLE; latency LOAD->register = ADDR_WIDTH+2 clocks decimal, 2 clocks hex.
REQ-018 Input changes while busy SHALL be ignored until IDLE, then detected; display register never shows a mix of old and new digits.
REQ-019 Overflow SHALL be set when value needs more than DIGITS digits (decimal: BCD carry beyond DIGITS nibbles; hex: nonzero bits above 4*DIGITS); on overflow every digit shows dash 8'b10111111.
REQ-020 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count digit index advances 0..DIGITS-1, wrapping to 0.
REQ-021 Digit index k (0 = most significant) SHALL drive digits[DIGITS-1-k] active, all others inactive.
REQ-022 First clock of every slot SHALL drive all digit selects inactive (anti-ghosting) while sseg_indicator updates to new digit code.
REQ-023 Encoding (active-low form, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E; blank FF; dash BF.
REQ-024 With blank_leading=1, zero digits left of the most significant nonzero digit SHALL show blank; least significant digit always shown.
REQ-025 ACTIVE_LOW=0 SHALL bitwise invert sseg_indicator and digits relative to REQ-021..REQ-024.

Reset
REQ-026 While reset=0: sseg_indicator all segments off, digits all inactive, busy=0, prescaler=0, digit index=0, display register=0, overflow=0, FSM=IDLE, start-pending flag set.
REQ-027 Reset assertion mid-conversion or mid-scan SHALL take effect asynchronously without waiting for a clock edge.

Structure
REQ-028 Shared package sseg_display_pkg SHALL hold FSM state type, 16 glyph constants, BLANK and DASH codes.
REQ-029 Sequential double-dabble SHALL be sub-module bin_to_bcd_seq (start/busy/done handshake); scan and glyph logic stay in top.

Verification
REQ-030 Reset low mid-scan -> same-cycle sseg_indicator=8'hFF, digits=4'b1111, busy=0.
REQ-031 Decimal 9'd359, blank_leading=1, REFRESH_DIV=4 -> busy high 11 clocks; scan: digits 0111/FF, 1011/B0, 1101/92, 1110/90.
REQ-032 hex_mode=1, 9'h1A5, blank_leading=0 -> busy 2 clocks; scan C0, F9, 88, 92.
REQ-033 DIGITS=2, decimal 9'd300 -> both digits BF; then 9'd42 -> 99, A4.
REQ-034 Change 9'd359->9'd7 on 3rd SHIFT cycle -> display shows full 359, then 7 (blanked to FF,FF,FF,F8); no mixed value.
REQ-035 REFRESH_DIV=4 free run -> index 0,1,2,3,0 every 4 clocks; first clock of each slot digits=4'b1111.
